// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, constants and helpers for fifo_wr_arbiter
//
// Purpose: holds the arbiter state encoding, the stall counter width, and the
//          helper that sizes the per-grant beat counter from BURST.
// Ports:   none (package).

package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STALL_CNT_W = 16;

  // The counter must be able to hold values 0..BURST.
  function automatic int cnt_width(input int burst);
    return $clog2(burst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - combinational round-robin picker
//
// Purpose: returns the first set bit of req in the search order
//          last+1, last+2, ... wrapping, ending with last itself.
// Ports:
//   req       in   NREQ   candidate vector (exclusions already applied)
//   last      in   IDX_W  index of the most recent grant
//   pick      out  NREQ   one-hot winner, zero when req is zero
//   pick_idx  out  IDX_W  index of the winner, zero when req is zero

module rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx
);

  // Walk the order backwards so the earliest candidate in search order is
  // the last one written and therefore wins.
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(last) + k) % NREQ;
      if (req[j[IDX_W-1:0]]) begin
        pick                = '0;
        pick[j[IDX_W-1:0]]  = 1'b1;
        pick_idx            = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
//
// Purpose: shares one FIFO write port between NREQ write-domain requesters.
//          One requester holds the grant for up to BURST accepted beats;
//          beats are accepted combinationally and stall while wfull is high.
// Optional feature: define FIFO_ARB_STATS_EN to add the stall_cnt output.
// Ports:
//   wclk       in   1           write clock, all logic on posedge
//   wrstn      in   1           asynchronous active-low reset
//   req        in   NREQ        per-requester beat valid
//   req_data   in   NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//   ack        out  NREQ        beat accepted this cycle
//   wfull      in   1           FIFO full
//   winc       out  1           FIFO write enable
//   wdata      out  WIDTH       FIFO write data
//   gnt        out  NREQ        registered one-hot grant
//   busy       out  1           grant held
//   stall_cnt  out  16          saturating stall cycle count (FIFO_ARB_STATS_EN)

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = cnt_width(BURST);

  arb_state_t       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  others;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_req;
  logic             burst_done;
  logic             release_now;

  // Beat path: purely combinational from the registered grant so that
  // winc can never be high in a cycle where wfull is high.
  always_comb begin
    ack = '0;
    if (state_q == GRANT) begin
      ack = gnt_q & req & {NREQ{~wfull}};
    end
  end

  assign winc = |ack;

  always_comb begin
    wdata = '0;
    if (state_q == GRANT) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q[i]) begin
          wdata = wdata | req_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign hold_req    = |(gnt_q & req);
  assign burst_done  = winc && (cnt_q == CNT_W'(BURST - 1));
  assign release_now = (state_q == GRANT) && (burst_done || !hold_req);

  // A holder that just used a full burst steps aside unless nobody else
  // is asking. When it dropped req instead, req already excludes it.
  assign others = req & ~gnt_q;
  assign elig   = (burst_done && (|others)) ? others : req;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req      (elig),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = GRANT;
          gnt_d   = pick;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          cnt_d = '0;
          if (|elig) begin
            // Regrant in the same edge: no idle bubble between holders.
            gnt_d  = pick;
            last_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (winc) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == GRANT);

`ifdef FIFO_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   stall_cyc;

  assign stall_cyc = busy & hold_req & wfull;

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      stall_q <= '0;
    end else if (stall_cyc && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter

module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrstn;
  logic [3:0]  req, req1;
  logic [31:0] req_data, req_data1;
  logic        wfull, wfull1;
  logic [3:0]  ack, ack1, gnt, gnt1;
  logic        winc, winc1, busy, busy1;
  logic [7:0]  wdata, wdata1;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt, stall_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int beats;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(4)) u_dut (
    .wclk     (wclk),
    .wrstn    (wrstn),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .gnt      (gnt),
    .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .BURST(1)) u_dut_b1 (
    .wclk     (wclk),
    .wrstn    (wrstn),
    .req      (req1),
    .req_data (req_data1),
    .ack      (ack1),
    .wfull    (wfull1),
    .winc     (winc1),
    .wdata    (wdata1),
    .gnt      (gnt1),
    .busy     (busy1)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  initial begin
    wrstn     = 1'b0;
    req       = '0;
    req1      = '0;
    req_data  = '0;
    req_data1 = '0;
    wfull     = 1'b0;
    wfull1    = 1'b0;
    beats     = 0;
    tick();
    tick();

    // reset state
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_winc", 32'(winc), 32'h0);
    chk("rst_wdata", 32'(wdata), 32'h0);

    // single requester, burst of 4, continuous regrant
    wrstn    = 1'b1;
    req      = 4'b0001;
    req_data = 32'h0000_0011;
    #1;
    chk("a_idle_ack", 32'(ack), 32'h0);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("a_gnt", 32'(gnt), 32'h1);
      chk("a_ack", 32'(ack), 32'h1);
      chk("a_winc", 32'(winc), 32'h1);
      chk("a_wdata", 32'(wdata), 32'h11);
      tick();
    end
    chk("a_regrant_gnt", 32'(gnt), 32'h1);
    chk("a_regrant_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    #1;
    chk("a_drop_winc", 32'(winc), 32'h0);
    tick();
    chk("a_idle_busy", 32'(busy), 32'h0);
    chk("a_idle_gnt", 32'(gnt), 32'h0);

    // all four requesting: order 0,1,2,3,0, 4 beats each, no bubble
    wrstn = 1'b0;
    #1;
    wrstn    = 1'b1;
    req      = 4'b1111;
    req_data = 32'hA3A2_A1A0;
    tick();
    for (int gi = 0; gi < 5; gi++) begin
      for (int b = 0; b < 4; b++) begin
        chk("b_gnt", 32'(gnt), 32'h1 << (gi % 4));
        chk("b_ack", 32'(ack), 32'h1 << (gi % 4));
        chk("b_wdata", 32'(wdata), 32'hA0 + 32'(gi % 4));
        chk("b_busy", 32'(busy), 32'h1);
        tick();
      end
    end
    tick();
    tick();
    chk("e_pre_gnt", 32'(gnt), 32'h2);

    // reset mid-burst: outputs drop immediately
    wrstn = 1'b0;
    #1;
    chk("e_gnt", 32'(gnt), 32'h0);
    chk("e_busy", 32'(busy), 32'h0);
    chk("e_ack", 32'(ack), 32'h0);
    chk("e_winc", 32'(winc), 32'h0);
    chk("e_wdata", 32'(wdata), 32'h0);
    tick();
    wrstn = 1'b1;
    tick();
    chk("e_first_gnt", 32'(gnt), 32'h1);

    // wfull stall on the third beat for 5 cycles
    for (int b = 0; b < 2; b++) begin
      chk("d_ack", 32'(ack), 32'h1);
      beats += int'(winc);
      tick();
    end
    wfull = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("d_stall_ack", 32'(ack), 32'h0);
      chk("d_stall_winc", 32'(winc), 32'h0);
      chk("d_stall_gnt", 32'(gnt), 32'h1);
      beats += int'(winc);
      tick();
    end
    wfull = 1'b0;
    #1;
    for (int b = 0; b < 2; b++) begin
      chk("d_ack2", 32'(ack), 32'h1);
      beats += int'(winc);
      tick();
    end
    chk("d_beats", 32'(beats), 32'd4);
    chk("d_next_gnt", 32'(gnt), 32'h2);
`ifdef FIFO_ARB_STATS_EN
    chk("d_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // requester 2 alone, drops after 2 beats; next grant from index 3
    req = 4'b0100;
    #1;
    chk("c_handoff_ack", 32'(ack), 32'h0);
    tick();
    chk("c_gnt", 32'(gnt), 32'h4);
    for (int b = 0; b < 2; b++) begin
      chk("c_ack", 32'(ack), 32'h4);
      tick();
    end
    req = 4'b0000;
    #1;
    chk("c_drop_winc", 32'(winc), 32'h0);
    chk("c_drop_busy", 32'(busy), 32'h1);
    tick();
    chk("c_idle_busy", 32'(busy), 32'h0);
    chk("c_idle_gnt", 32'(gnt), 32'h0);
    req = 4'b1111;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("c_gnt3", 32'(gnt), 32'h8);
      chk("c_ack3", 32'(ack), 32'h8);
      tick();
    end
    chk("c_wrap_gnt", 32'(gnt), 32'h1);

    // BURST=1 instance: grant alternates every beat
    req       = 4'b0000;
    req1      = 4'b0101;
    req_data1 = 32'h1312_1110;
    #1;
    chk("f_idle_gnt", 32'(gnt1), 32'h0);
    tick();
    for (int c = 0; c < 6; c++) begin
      chk("f_gnt", 32'(gnt1), (c % 2 == 0) ? 32'h1 : 32'h4);
      chk("f_ack", 32'(ack1), (c % 2 == 0) ? 32'h1 : 32'h4);
      chk("f_wdata", 32'(wdata1), (c % 2 == 0) ? 32'h10 : 32'h12);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the asynchronous FIFO between NREQ requesters in the write clock domain. It grants one requester at a time in round-robin order and holds the grant for a burst of up to BURST accepted beats. It drives winc/wdata into the FIFO and respects wfull so that no beat is lost or duplicated.

## Interface
- NREQ, 4: number of requesters, 2..16
- WIDTH, 8: data width; matches the FIFO WIDTH
- BURST, 4: maximum accepted beats per grant, ≥1
- wclk  in  1  write-domain clock; all logic on posedge
- wrstn  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester beat-valid; data is held stable while req is high
- req_data  in  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- ack  out  NREQ  beat accepted this cycle (one-hot or zero)
- wfull  in  1  FIFO full flag
- winc  out  1  FIFO write enable
- wdata  out  WIDTH  FIFO write data
- gnt  out  NREQ  registered one-hot grant
- busy  out  1  grant held (state GRANT)

## Operation
- States:
  - IDLE: gnt=0.
  - GRANT: gnt one-hot = g.
- Round-robin pointer `last` (log2 NREQ bits) holds the index of the most recent grant. Search order is last+1, last+2, … wrapping, ending with last itself.
- IDLE: if |req at an edge, grant the first requesting index in search order, go to GRANT, load `last` with that index, and set beat count to 0. Otherwise stay in IDLE.
- GRANT beat handling, all combinational in the same cycle:
  - ack[g] = req[g] & !wfull
  - winc = |ack
  - wdata = req_data slice g while in GRANT, else 0
- Beat counter width clog2(BURST+1); increments on each ack.
- A release edge occurs when either:
  - a beat is accepted with count == BURST-1, or
  - req[g]==0.
- At a release edge:
  - If |req, excluding g when g has just finished a full burst, regrant immediately in search order from the new `last`=g. No idle bubble.
  - Otherwise go to IDLE.
  - g remains eligible only if it is the sole requester.
- While wfull is high in GRANT: no ack, count frozen, grant held indefinitely (no timeout).

## Timing
- Reset values: gnt=0, busy=0, ack=0, winc=0, wdata=0, state IDLE, count 0, `last`=NREQ-1 (so requester 0 wins first).
- Request-to-grant latency: one wclk edge from IDLE. ack may assert in the first GRANT cycle.
- ack, winc and wdata are combinational from the registered gnt and the live req/wfull. There is no register between wfull and winc, so winc never asserts while wfull is high.
- Back-to-back grants to different requesters at a release edge: zero bubble cycles.
- Reset asserted mid-burst: all outputs drop asynchronously; the in-flight beat is not written.

## Configuration
- FIFO_ARB_STATS_EN defined: adds output stall_cnt (16 bits).
  - Increments each cycle with busy & req[g] & wfull.
  - Saturates at 0xFFFF; cleared only by reset.
- Not defined: port and logic absent. All other behaviour is identical.

## Structure
- Package fifo_arb_pkg:
  - state enum {IDLE, GRANT}
  - STALL_CNT_W=16
  - helper function for the count width from BURST
- Sub-module rr_picker: purely combinational.
  - Inputs: req vector and `last`.
  - Outputs: one-hot pick and its index.
  - Instantiated once; the exclude mask for the finished holder is applied at its req input.

## Test plan
- Reset, then req=4'b0001 with data 0x11 held and wfull=0 → gnt=0001 after 1 edge; 4 acks and 4 winc with wdata=0x11; release; since the only requester continues, gnt stays 0001 for the next burst.
- req=4'b1111 constantly → grant order 0,1,2,3,0; each holds exactly 4 beats; no idle cycle between grants.
- Requester 2 alone, drops req after 2 beats → release at that edge, busy=0 next cycle, count resets, the next grant starts at index 3.
- wfull=1 during beat 3 of a burst for 5 cycles → winc=0 and ack=0 for those cycles; gnt held; exactly 4 total beats written; with FIFO_ARB_STATS_EN, stall_cnt=5.
- wrstn pulsed low mid-burst under req=1111 → outputs zero immediately; after release, requester 0 is granted first.
- BURST=1, req=0101 → gnt alternates 0001, 0100 every beat.
